vend_key_fsm: RTL and testbench
===============================

# vend_key_fsm

Vending-machine transaction controller sitting directly downstream of the UART receiver. Consumes each received ASCII byte with its one-cycle valid strobe, interprets it as a coin, a product selection or a cancel, and tracks credit. Drives a timed dispense motor and reports change, refund and error events to the display/LED logic.

## Interface
- PRICE1, default 25: item 1 price, cents
- PRICE2, default 50: item 2 price
- PRICE3, default 75: item 3 price
- PRICE4, default 100: item 4 price
- MAX_CREDIT, default 150: credit ceiling, ≤ 255
- DISPENSE_CYCLES, default 4: motor-on duration in clocks, ≥ 1
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock domain
- rx_data  in  8  received ASCII byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- credit  out  8  current credit, cents
- motor_on  out  1  high during dispense
- item  out  2  selected item index (0..3 = keys '1'..'4'), valid while motor_on
- change  out  8  cents returned, valid with change_valid
- change_valid  out  1  one-cycle pulse
- err  out  1  one-cycle pulse
- err_code  out  3  1 unknown key, 2 insufficient credit, 3 credit ceiling, 4 busy; valid with err
- busy  out  1  high in DISPENSE

## Operation
- Keys: 'n'(0x6E)=+5, 'd'(0x64)=+10, 'q'(0x71)=+25; '1'..'4'(0x31..0x34) select; 'c'(0x63) cancel. All other bytes are unknown → err, code 1.
- States: IDLE (credit 0), CREDIT (credit > 0), DISPENSE.
- Coin in IDLE/CREDIT: if credit + value ≤ MAX_CREDIT, credit increases → CREDIT. Otherwise the coin is rejected: credit unchanged, err code 3, change = value, change_valid.
- Select with credit ≥ price → DISPENSE: motor_on and item are latched, and credit is held.
- Select with credit < price: err code 2, no state change.
- Cancel in CREDIT: change = credit, change_valid, credit → 0, → IDLE. Cancel in IDLE: no action and no error.
- DISPENSE: counter runs DISPENSE_CYCLES clocks. On the last cycle: change = credit − price, change_valid (pulses even when 0), credit → 0, → IDLE.
- rx_valid in DISPENSE: byte dropped, err code 4. Coins are not queued.
- Arithmetic is 9-bit internally for the ceiling check; credit never exceeds MAX_CREDIT.

## Timing
- Reset values: credit 0, motor_on 0, item 0, change 0, change_valid 0, err 0, err_code 0, busy 0, state IDLE, counter 0.
- All outputs are registered. Effects of a byte appear on the clock after its rx_valid cycle.
- motor_on and busy rise one clock after the accepted select and stay high for exactly DISPENSE_CYCLES clocks.
- change_valid pulses on the clock after the final motor_on cycle. On that same clock, credit reads 0 and the block accepts input again.
- err and change_valid are single-cycle. A rejected coin pulses both on the same clock.
- change holds its last value until the next change_valid. err_code holds until the next err.
- Back-to-back rx_valid on consecutive clocks is handled with no loss in IDLE/CREDIT.
- Reset mid-dispense: motor drops immediately next clock, credit is lost, and no change is reported.

## Structure
- vend_pkg holds:
  - ASCII key constants
  - coin values
  - err_code localparams
  - state enum (IDLE/CREDIT/DISPENSE)
- One combinational sub-module, vend_key_decode: rx_data → {is_coin, is_sel, is_cancel, coin_value[4:0], sel_idx[1:0]}.
- The price mux from the PRICEn parameters lives in the FSM.

## Test plan
- Reset, then 'q','q','d' → credit 25, 50, 60. Then '2' → motor_on for 4 clocks with item=1, then change=10 pulse and credit 0.
- 'q'×6 then 'q' → the 7th is rejected: err code 3, change=25, and credit stays 150.
- 'd' then '4' → err code 2, credit 10. Then 'c' → change=10, credit 0, IDLE.
- 'q','1' then 'n' during motor_on → err code 4 and credit unaffected. After dispense, change=0 pulses.
- Byte 0x41 'A' → err code 1, no state change. 'c' in IDLE → no pulses.
- Reset asserted on the 2nd motor_on cycle → all outputs 0 the next clock, and no change_valid.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared constants and types for the vending key controller.
// Holds ASCII keys, coin values, error codes and the FSM state enum.
package vend_pkg;

  localparam logic [7:0] KEY_N = 8'h6E;
  localparam logic [7:0] KEY_D = 8'h64;
  localparam logic [7:0] KEY_Q = 8'h71;
  localparam logic [7:0] KEY_1 = 8'h31;
  localparam logic [7:0] KEY_2 = 8'h32;
  localparam logic [7:0] KEY_3 = 8'h33;
  localparam logic [7:0] KEY_4 = 8'h34;
  localparam logic [7:0] KEY_C = 8'h63;

  localparam logic [4:0] VAL_N = 5'd5;
  localparam logic [4:0] VAL_D = 5'd10;
  localparam logic [4:0] VAL_Q = 5'd25;

  localparam logic [2:0] ERR_UNKNOWN = 3'd1;
  localparam logic [2:0] ERR_FUNDS   = 3'd2;
  localparam logic [2:0] ERR_CEIL    = 3'd3;
  localparam logic [2:0] ERR_BUSY    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_DISPENSE
  } state_t;

endpackage

// File: rtl/vend_key_fsm_if.sv
// Received-byte bus from the UART receiver into the controller.
// rx_data: ASCII byte; rx_valid: one-cycle strobe qualifying rx_data.
interface vend_key_fsm_if;

  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output rx_data,
    output rx_valid
  );

  modport slave (
    input rx_data,
    input rx_valid
  );

endinterface

// File: rtl/vend_key_decode.sv
// Combinational classifier for a received byte: coin, select, cancel.
// In: rx_data. Out: is_coin/is_sel/is_cancel, coin_value, sel_idx.
module vend_key_decode
  import vend_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic       is_coin,
  output logic       is_sel,
  output logic       is_cancel,
  output logic [4:0] coin_value,
  output logic [1:0] sel_idx
);

  always_comb begin
    is_coin    = 1'b0;
    is_sel     = 1'b0;
    is_cancel  = 1'b0;
    coin_value = 5'd0;
    sel_idx    = 2'd0;
    case (rx_data)
      KEY_N: begin
        is_coin    = 1'b1;
        coin_value = VAL_N;
      end
      KEY_D: begin
        is_coin    = 1'b1;
        coin_value = VAL_D;
      end
      KEY_Q: begin
        is_coin    = 1'b1;
        coin_value = VAL_Q;
      end
      KEY_1: begin
        is_sel  = 1'b1;
        sel_idx = 2'd0;
      end
      KEY_2: begin
        is_sel  = 1'b1;
        sel_idx = 2'd1;
      end
      KEY_3: begin
        is_sel  = 1'b1;
        sel_idx = 2'd2;
      end
      KEY_4: begin
        is_sel  = 1'b1;
        sel_idx = 2'd3;
      end
      KEY_C: is_cancel = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/vend_key_fsm.sv
// Vending transaction controller: credit tracking, timed dispense, events.
// Ports: clk, reset (sync high), rx bus, credit/motor/item/change/err/busy.
module vend_key_fsm
  import vend_pkg::*;
#(
  parameter int PRICE1          = 25,
  parameter int PRICE2          = 50,
  parameter int PRICE3          = 75,
  parameter int PRICE4          = 100,
  parameter int MAX_CREDIT      = 150,
  parameter int DISPENSE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  vend_key_fsm_if.slave        rx,
  output logic [7:0]           credit,
  output logic                 motor_on,
  output logic [1:0]           item,
  output logic [7:0]           change,
  output logic                 change_valid,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic                 busy
);

  localparam int CW = $clog2(DISPENSE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DISPENSE_CYCLES - 1);
  localparam logic [8:0] MAX9 = 9'(MAX_CREDIT);

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    logic [7:0] p;
    unique case (idx)
      2'd0: p = 8'(PRICE1);
      2'd1: p = 8'(PRICE2);
      2'd2: p = 8'(PRICE3);
      2'd3: p = 8'(PRICE4);
    endcase
    return p;
  endfunction

  logic       is_coin;
  logic       is_sel;
  logic       is_cancel;
  logic [4:0] coin_value;
  logic [1:0] sel_idx;

  vend_key_decode u_dec (
    .rx_data    (rx.rx_data),
    .is_coin    (is_coin),
    .is_sel     (is_sel),
    .is_cancel  (is_cancel),
    .coin_value (coin_value),
    .sel_idx    (sel_idx)
  );

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    credit_n;
  logic          motor_n;
  logic [1:0]    item_n;
  logic [7:0]    change_n;
  logic          cv_n;
  logic          err_n;
  logic [2:0]    ec_n;
  logic          busy_n;
  logic [8:0]    sum9;

  // Widened so a coin that would overshoot 255 is still caught.
  assign sum9 = {1'b0, credit} + {4'b0, coin_value};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      credit       <= 8'd0;
      motor_on     <= 1'b0;
      item         <= 2'd0;
      change       <= 8'd0;
      change_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= 3'd0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      credit       <= credit_n;
      motor_on     <= motor_n;
      item         <= item_n;
      change       <= change_n;
      change_valid <= cv_n;
      err          <= err_n;
      err_code     <= ec_n;
      busy         <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    credit_n = credit;
    motor_n  = motor_on;
    item_n   = item;
    change_n = change;
    cv_n     = 1'b0;
    err_n    = 1'b0;
    ec_n     = err_code;
    busy_n   = busy;
    case (state)
      S_IDLE, S_CREDIT: begin
        if (rx.rx_valid) begin
          unique case (1'b1)
            is_coin: begin
              if (sum9 <= MAX9) begin
                credit_n = sum9[7:0];
                state_n  = S_CREDIT;
              end else begin
                err_n    = 1'b1;
                ec_n     = ERR_CEIL;
                change_n = {3'b0, coin_value};
                cv_n     = 1'b1;
              end
            end
            is_sel: begin
              if (credit >= price_of(sel_idx)) begin
                state_n = S_DISPENSE;
                cnt_n   = '0;
                motor_n = 1'b1;
                busy_n  = 1'b1;
                item_n  = sel_idx;
              end else begin
                err_n = 1'b1;
                ec_n  = ERR_FUNDS;
              end
            end
            is_cancel: begin
              if (state == S_CREDIT) begin
                change_n = credit;
                cv_n     = 1'b1;
                credit_n = 8'd0;
                state_n  = S_IDLE;
              end
            end
            default: begin
              err_n = 1'b1;
              ec_n  = ERR_UNKNOWN;
            end
          endcase
        end
      end
      S_DISPENSE: begin
        if (rx.rx_valid) begin
          err_n = 1'b1;
          ec_n  = ERR_BUSY;
        end
        if (cnt == CNT_LAST) begin
          change_n = credit - price_of(item);
          cv_n     = 1'b1;
          credit_n = 8'd0;
          motor_n  = 1'b0;
          busy_n   = 1'b0;
          cnt_n    = '0;
          state_n  = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_key_fsm.sv
// Scoreboard bench for vend_key_fsm with directed key sequences.
// Expected err/change events are queued; a negedge monitor pops them.
module tb_vend_key_fsm;
  import vend_pkg::*;

  typedef struct {
    logic       err;
    logic [2:0] code;
    logic       cv;
    logic [7:0] change;
    logic [7:0] credit;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] credit;
  logic       motor_on;
  logic [1:0] item;
  logic [7:0] change;
  logic       change_valid;
  logic       err;
  logic [2:0] err_code;
  logic       busy;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  vend_key_fsm_if bus ();

  vend_key_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (bus),
    .credit       (credit),
    .motor_on     (motor_on),
    .item         (item),
    .change       (change),
    .change_valid (change_valid),
    .err          (err),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic e, input logic [2:0] c,
                           input logic v, input logic [7:0] ch,
                           input logic [7:0] cr);
    exp_t x;
    x.err = e;
    x.code = c;
    x.cv = v;
    x.change = ch;
    x.credit = cr;
    sb.push_back(x);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " credit"}, credit, 0);
    chk({tag, " motor_on"}, motor_on, 0);
    chk({tag, " item"}, item, 0);
    chk({tag, " change"}, change, 0);
    chk({tag, " change_valid"}, change_valid, 0);
    chk({tag, " err"}, err, 0);
    chk({tag, " err_code"}, err_code, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && (err || change_valid)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected event: err=%0d code=%0d cv=%0d chg=%0d",
                 err, err_code, change_valid, change);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("ev err", err, x.err);
        chk("ev change_valid", change_valid, x.cv);
        if (x.err) chk("ev err_code", err_code, x.code);
        if (x.cv) chk("ev change", change, x.change);
        chk("ev credit", credit, x.credit);
      end
    end
  end

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    idle(3);
    chk_zero("reset");
    reset = 1'b0;
    idle(1);

    send(KEY_Q);
    chk("q1 credit", credit, 25);
    send(KEY_Q);
    chk("q2 credit", credit, 50);
    send(KEY_D);
    chk("d credit", credit, 60);
    expect_ev(1'b0, 3'd0, 1'b1, 8'd10, 8'd0);
    send(KEY_2);
    for (int i = 0; i < 4; i++) begin
      chk("disp motor_on", motor_on, 1);
      chk("disp busy", busy, 1);
      chk("disp item", item, 1);
      chk("disp credit", credit, 60);
      idle(1);
    end
    chk("after disp motor_on", motor_on, 0);
    chk("after disp credit", credit, 0);
    idle(1);

    repeat (6) send(KEY_Q);
    chk("six q credit", credit, 150);
    expect_ev(1'b1, ERR_CEIL, 1'b1, 8'd25, 8'd150);
    send(KEY_Q);
    chk("ceil credit", credit, 150);
    expect_ev(1'b0, 3'd0, 1'b1, 8'd150, 8'd0);
    send(KEY_C);
    chk("cancel150 credit", credit, 0);
    idle(1);

    send(KEY_D);
    expect_ev(1'b1, ERR_FUNDS, 1'b0, 8'd0, 8'd10);
    send(KEY_4);
    chk("funds motor_on", motor_on, 0);
    chk("funds credit", credit, 10);
    expect_ev(1'b0, 3'd0, 1'b1, 8'd10, 8'd0);
    send(KEY_C);
    chk("cancel10 credit", credit, 0);
    idle(1);

    send(KEY_Q);
    send(KEY_1);
    chk("busy motor_on", motor_on, 1);
    expect_ev(1'b1, ERR_BUSY, 1'b0, 8'd0, 8'd25);
    expect_ev(1'b0, 3'd0, 1'b1, 8'd0, 8'd0);
    send(KEY_N);
    chk("busy credit", credit, 25);
    chk("busy motor still", motor_on, 1);
    idle(3);
    chk("busy end motor_on", motor_on, 0);
    chk("busy end credit", credit, 0);
    idle(1);

    expect_ev(1'b1, ERR_UNKNOWN, 1'b0, 8'd0, 8'd0);
    send(8'h41);
    chk("unknown credit", credit, 0);
    chk("unknown motor_on", motor_on, 0);
    send(KEY_C);
    chk("idle cancel cv", change_valid, 0);
    chk("idle cancel err", err, 0);
    idle(2);

    send(KEY_Q);
    send(KEY_1);
    idle(1);
    chk("pre-reset motor_on", motor_on, 1);
    reset = 1'b1;
    idle(1);
    chk_zero("mid reset");
    reset = 1'b0;
    idle(8);
    chk("mid reset no cv", change_valid, 0);

    chk("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
